// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the CPU MEM stage and a req/ack word memory.
// Define MISALIGN_TRAP_EN to fault misaligned word/halfword accesses instead of forcing alignment.
module lsu_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        cpu_resp_valid,
    input  logic        cpu_resp_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_timeout,
    output logic        cpu_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | ready for a CPU access
    // ISSUE | mem_req held until ack or timeout
    // RESP  | response held until the CPU consumes it
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q, load_data;
    logic        timeout_q, fault_q;
    logic [7:0]  count;
    logic        accept, misaligned, timeout_hit;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic        unused_pc;

    // The PC only feeds simulation traces; nothing in the datapath needs it.
    assign unused_pc   = ^cpu_pc;
    assign accept      = cpu_req_valid && cpu_req_ready;
    assign timeout_hit = (count == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (((cpu_op == 3'b000) || (cpu_op == 3'b101)) && (cpu_addr[1:0] != 2'b00)) ||
                        (((cpu_op == 3'b001) || (cpu_op == 3'b010) || (cpu_op == 3'b110)) && cpu_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = misaligned ? RESP : ISSUE;
            ISSUE:   if (mem_ack || timeout_hit) state_next = RESP;
            RESP:    if (cpu_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
    end

    // Stores fall through to zero so their response carries rdata = 0.
    always_comb begin
        load_data = 32'd0;
        case (op_q)
            3'b000:  load_data = mem_rdata;
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = {16'd0, half_sel};
            3'b011:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            default: load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
            count     <= 8'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q      <= cpu_op;
                    addr_q    <= cpu_addr;
                    wdata_q   <= cpu_wdata;
                    rdata_q   <= 32'd0;
                    timeout_q <= 1'b0;
                    fault_q   <= misaligned;
                    count     <= 8'd0;
                end
                ISSUE: begin
                    // An ack in the terminal-count cycle takes priority over the timeout.
                    if (mem_ack)          rdata_q   <= load_data;
                    else if (timeout_hit) timeout_q <= 1'b1;
                    else                  count     <= count + 8'd1;
                end
                RESP: if (cpu_resp_ready) begin
                    rdata_q   <= 32'd0;
                    timeout_q <= 1'b0;
                    fault_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = 32'd0;
        cpu_timeout    = 1'b0;
        cpu_fault      = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_be         = 4'b0000;
        mem_addr       = 32'd0;
        mem_wdata      = 32'd0;
        case (state)
            IDLE: cpu_req_ready = !reset;
            ISSUE: begin
                mem_req  = 1'b1;
                mem_we   = op_q[2] && (op_q != 3'b100);
                mem_addr = {addr_q[31:2], 2'b00};
                case (op_q)
                    3'b000, 3'b101: begin
                        mem_be    = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                    3'b001, 3'b010, 3'b110: begin
                        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_be    = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                endcase
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_rdata      = rdata_q;
                cpu_timeout    = timeout_q;
                cpu_fault      = fault_q;
            end
            default: ;
        endcase
    end

endmodule
